// File: rtl/spmv_csr_writer_pkg.sv
// Shared CSR layout constants, state encoding and row_ptr helper for the SpMV load/read blocks.
// Used by spmv_csr_writer and by the SRAM read path so both sides agree on the bank layout.
package spmv_pkg;

  localparam int N_ROWS   = 16;
  localparam int MAX_NNZ  = 64;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;
  localparam int VAL_BASE = 0;
  localparam int RP_BASE  = 0;
  localparam int COL_BASE = 32;

  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  localparam int K_W        = 8;
  localparam int CUR_W      = $clog2(N_ROWS + 1);
  localparam int RP_ENTRIES = N_ROWS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RP0,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  // row_ptr words never exceed the nonzero capacity, even if k has run past it
  function automatic logic [DATA_W-1:0] rp_value(input logic [K_W-1:0] k);
    return (k > K_W'(MAX_NNZ)) ? DATA_W'(MAX_NNZ) : DATA_W'(k);
  endfunction

endpackage

// File: rtl/spmv_csr_writer_if.sv
// Row-major nonzero entry stream (row, col, value, last) with valid/ready handshake.
interface spmv_csr_writer_if;
  import spmv_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [ROW_W-1:0]  i_row;
  logic [COL_W-1:0]  i_col;
  logic [DATA_W-1:0] i_val;
  logic              i_last;

  modport master (output i_valid, i_row, i_col, i_val, i_last, input o_ready);
  modport slave  (input i_valid, i_row, i_col, i_val, i_last, output o_ready);

endinterface

// File: rtl/spmv_csr_writer_rowptr_gen.sv
// Owns cur_row and k; muxes the single SRAM B write port between row_ptr[0], col_idx and row_ptr advances.
// Writes are combinational in the requesting cycle; the caller guarantees at most one request per cycle.
module spmv_rowptr_gen
  import spmv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clear,
  input  logic              i_rp0_we,
  input  logic              i_col_we,
  input  logic [COL_W-1:0]  i_col,
  input  logic              i_adv,
  output logic [K_W-1:0]    o_k,
  output logic [CUR_W-1:0]  o_cur_row,
  output logic              o_we_B,
  output logic [ADDR_W-1:0] o_addr_B,
  output logic [DATA_W-1:0] o_wdata_B
);

  logic [K_W-1:0]   k_q, k_d;
  logic [CUR_W-1:0] cur_q, cur_d;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      k_q   <= '0;
      cur_q <= '0;
    end else begin
      k_q   <= k_d;
      cur_q <= cur_d;
    end
  end

  always_comb begin
    k_d   = k_q;
    cur_d = cur_q;
    if (i_clear) begin
      k_d   = '0;
      cur_d = '0;
    end else begin
      if (i_col_we) k_d   = k_q + K_W'(1);
      if (i_adv)    cur_d = cur_q + CUR_W'(1);
    end
  end

  always_comb begin
    o_we_B    = 1'b0;
    o_addr_B  = '0;
    o_wdata_B = '0;
    if (i_rp0_we) begin
      o_we_B   = 1'b1;
      o_addr_B = ADDR_W'(RP_BASE);
    end else if (i_col_we) begin
      o_we_B    = 1'b1;
      o_addr_B  = ADDR_W'(COL_BASE) + ADDR_W'(k_q);
      o_wdata_B = DATA_W'(i_col);
    end else if (i_adv) begin
      // advancing past cur_row closes it: row_ptr[cur_row+1] = entries so far
      o_we_B    = 1'b1;
      o_addr_B  = ADDR_W'(RP_BASE) + ADDR_W'(cur_q) + ADDR_W'(1);
      o_wdata_B = rp_value(k_q);
    end
  end

  assign o_k       = k_q;
  assign o_cur_row = cur_q;

endmodule

// File: rtl/spmv_csr_writer.sv
// Streams row-major nonzeros into SRAM A (values) and SRAM B (col_idx + row_ptr) in CSR layout.
// Same-cycle writes; o_ready drops for one cycle per row advance. SPMV_CSR_ORDER_CHECK_EN enables malformed-input dropping and o_error.
module spmv_csr_writer
  import spmv_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  spmv_csr_writer_if.slave   s_if,
  output logic               o_we_A,
  output logic [ADDR_W-1:0]  o_addr_A,
  output logic [DATA_W-1:0]  o_wdata_A,
  output logic               o_we_B,
  output logic [ADDR_W-1:0]  o_addr_B,
  output logic [DATA_W-1:0]  o_wdata_B,
  output logic               o_busy,
  output logic               o_done,
  output logic [7:0]         o_nnz,
  output logic               o_error
);

  state_e           state_q, state_d;
  logic [K_W-1:0]   nnz_q, nnz_d;
  logic [K_W-1:0]   k;
  logic [CUR_W-1:0] cur_row, row_ext;
  logic             clear, rp0_we, col_we, adv, ready;
  logic             row_ahead, entry_bad, err_set;

  always_comb begin
    row_ext = CUR_W'(s_if.i_row);
`ifdef SPMV_CSR_ORDER_CHECK_EN
    // an out-of-range row never advances; it is consumed as an error instead
    row_ahead = (row_ext > cur_row) && (row_ext < CUR_W'(N_ROWS));
    entry_bad = (row_ext < cur_row) || (row_ext >= CUR_W'(N_ROWS)) || (k == K_W'(MAX_NNZ));
`else
    row_ahead = (row_ext > cur_row);
    entry_bad = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      nnz_q   <= '0;
    end else begin
      state_q <= state_d;
      nnz_q   <= nnz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nnz_d   = nnz_q;
    clear   = 1'b0;
    rp0_we  = 1'b0;
    col_we  = 1'b0;
    adv     = 1'b0;
    ready   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          clear   = 1'b1;
          nnz_d   = '0;
          state_d = S_RP0;
        end
      end
      S_RP0: begin
        rp0_we  = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (s_if.i_valid) begin
          if (row_ahead) begin
            adv = 1'b1;
          end else begin
            ready = 1'b1;
            if (entry_bad) err_set = 1'b1;
            else           col_we  = 1'b1;
            if (s_if.i_last) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        adv = 1'b1;
        if (cur_row == CUR_W'(N_ROWS - 1)) begin
          nnz_d   = k;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // nothing may reach the SRAMs while reset is being applied
    if (!i_rstn) begin
      rp0_we = 1'b0;
      col_we = 1'b0;
      adv    = 1'b0;
      ready  = 1'b0;
    end
  end

  spmv_rowptr_gen u_rowptr_gen (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clear   (clear),
    .i_rp0_we  (rp0_we),
    .i_col_we  (col_we),
    .i_col     (s_if.i_col),
    .i_adv     (adv),
    .o_k       (k),
    .o_cur_row (cur_row),
    .o_we_B    (o_we_B),
    .o_addr_B  (o_addr_B),
    .o_wdata_B (o_wdata_B)
  );

`ifdef SPMV_CSR_ORDER_CHECK_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (!i_rstn)                          err_q <= 1'b0;
    else if (clear)                       err_q <= 1'b0;
    else if (err_set)                     err_q <= 1'b1;
  end
  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  assign s_if.o_ready = ready;
  assign o_we_A       = col_we;
  assign o_addr_A     = col_we ? (ADDR_W'(VAL_BASE) + ADDR_W'(k)) : '0;
  assign o_wdata_A    = col_we ? s_if.i_val : '0;
  assign o_busy       = i_rstn && (state_q != S_IDLE);
  assign o_done       = i_rstn && (state_q == S_DONE);
  assign o_nnz        = nnz_q;

endmodule

// File: tb/tb_spmv_csr_writer.sv
// Self-checking bench: directed and random CSR loads compared against a row-count reference model.
module tb_spmv_csr_writer;
  import spmv_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic clr_mem = 1'b0;
  always #5 clk = ~clk;

  spmv_csr_writer_if sif();

  logic              we_A, we_B, busy, done, err;
  logic [ADDR_W-1:0] addr_A, addr_B;
  logic [DATA_W-1:0] wd_A, wd_B;
  logic [7:0]        nnz;

  spmv_csr_writer dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_start   (start),
    .s_if      (sif),
    .o_we_A    (we_A),
    .o_addr_A  (addr_A),
    .o_wdata_A (wd_A),
    .o_we_B    (we_B),
    .o_addr_B  (addr_B),
    .o_wdata_B (wd_B),
    .o_busy    (busy),
    .o_done    (done),
    .o_nnz     (nnz),
    .o_error   (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;

  // monitor-owned observations
  logic [DATA_W-1:0] mem_a [256];
  logic [DATA_W-1:0] mem_b [256];
  int cnt_a = 0, cnt_b = 0, done_cnt = 0, done_cyc = 0, stall_obs = 0, viol = 0;

  // stimulus and reference expectations
  int e_row[$], e_col[$], e_val[$];
  int exp_vals[$], exp_cols[$];
  int exp_rp[RP_ENTRIES];
  int exp_nnz, exp_stalls;
  bit exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = 16'hDEAD;
        mem_b[i] = 16'hDEAD;
      end
    end
    if (we_A) begin mem_a[addr_A] = wd_A; cnt_a++; end
    if (we_B) begin mem_b[addr_B] = wd_B; cnt_b++; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy && sif.i_valid && !sif.o_ready) stall_obs++;
    if (we_A && !(we_B && addr_B == ADDR_W'(COL_BASE) + (addr_A - ADDR_W'(VAL_BASE)))) viol++;
`ifndef SPMV_CSR_ORDER_CHECK_EN
    if (we_A !== (sif.i_valid && sif.o_ready)) viol++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CSR from first principles: row_ptr[i] = number of stored entries whose row is below i
  task automatic build_expect();
    int k, cur;
    int acc_row[$];
    exp_vals.delete(); exp_cols.delete();
    exp_err = 1'b0; exp_stalls = 0; k = 0; cur = 0;
    for (int i = 0; i < e_row.size(); i++) begin
      int r;
      r = e_row[i];
`ifdef SPMV_CSR_ORDER_CHECK_EN
      if (r < cur || r >= N_ROWS) begin exp_err = 1'b1; continue; end
`endif
      if (r > cur) begin exp_stalls += r - cur; cur = r; end
`ifdef SPMV_CSR_ORDER_CHECK_EN
      if (k == MAX_NNZ) begin exp_err = 1'b1; continue; end
`endif
      exp_vals.push_back(e_val[i]);
      exp_cols.push_back(e_col[i]);
      acc_row.push_back(cur);
      k++;
    end
    exp_nnz = k;
    for (int i = 0; i <= N_ROWS; i++) begin
      int c;
      c = 0;
      foreach (acc_row[j]) if (acc_row[j] < i) c++;
      exp_rp[i] = (c > MAX_NNZ) ? MAX_NNZ : c;
    end
  endtask

  task automatic run_load(input string name, input int gap_pct, input bit chk_lat);
    int idx, guard, n, start_cyc, a0, b0, d0, s0, v0;
    bit v;
    n = e_row.size();
    build_expect();
    @(posedge clk); #1;
    a0 = cnt_a; b0 = cnt_b; d0 = done_cnt; s0 = stall_obs; v0 = viol;
    start = 1'b1; clr_mem = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; clr_mem = 1'b0;
    idx = 0; guard = 0;
    while (idx < n) begin
      @(posedge clk); #1;
      v = ($urandom_range(99) >= gap_pct);
      sif.i_valid = v;
      sif.i_row   = ROW_W'(e_row[idx]);
      sif.i_col   = COL_W'(e_col[idx]);
      sif.i_val   = DATA_W'(e_val[idx]);
      sif.i_last  = (idx == n - 1);
      @(negedge clk);
      if (v && sif.o_ready) idx++;
      guard++;
      if (guard > 2000) begin chk({name, " stream_timeout"}, idx, n); break; end
    end
    @(posedge clk); #1;
    sif.i_valid = 1'b0; sif.i_last = 1'b0;
    for (int t = 0; t < 200 && done_cnt == d0; t++) @(negedge clk);
    chk({name, " done_seen"}, (done_cnt > d0), 1);
    repeat (4) @(negedge clk);
    chk({name, " done_once"}, done_cnt - d0, 1);
    chk({name, " busy_after"}, busy, 0);
    chk({name, " nnz"}, nnz, exp_nnz);
    chk({name, " error"}, err, exp_err);
    chk({name, " stalls"}, stall_obs - s0, exp_stalls);
    if (chk_lat) chk({name, " latency"}, done_cyc - start_cyc, N_ROWS + 2 + n);
    chk({name, " a_writes"}, cnt_a - a0, exp_nnz);
    chk({name, " b_writes"}, cnt_b - b0, exp_nnz + RP_ENTRIES);
    chk({name, " port_rules"}, viol - v0, 0);
    for (int k = 0; k < exp_nnz; k++) begin
      chk($sformatf("%s A[%0d]", name, VAL_BASE + k), mem_a[VAL_BASE + k], exp_vals[k]);
      chk($sformatf("%s B[%0d]", name, COL_BASE + k), mem_b[COL_BASE + k], exp_cols[k]);
    end
    for (int i = 0; i <= N_ROWS; i++)
      chk($sformatf("%s row_ptr[%0d]", name, i), mem_b[RP_BASE + i], exp_rp[i]);
  endtask

  task automatic gen_random(input int n);
    int rows[$];
    e_row.delete(); e_col.delete(); e_val.delete();
    for (int i = 0; i < n; i++) rows.push_back($urandom_range(N_ROWS - 1));
    rows.sort();
    foreach (rows[i]) begin
      e_row.push_back(rows[i]);
      e_col.push_back($urandom_range(15));
      e_val.push_back($urandom_range(16'hFFFF));
    end
  endtask

  task automatic set_diag();
    e_row = {0, 1, 2}; e_col = {0, 1, 2}; e_val = {5, 7, 9};
  endtask

  task automatic reset_mid_stream();
    int acc, guard;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    acc = 0; guard = 0;
    while (acc < 3 && guard < 100) begin
      @(posedge clk); #1;
      sif.i_valid = 1'b1; sif.i_row = ROW_W'(acc); sif.i_col = COL_W'(acc);
      sif.i_val = DATA_W'(100 + acc); sif.i_last = 1'b0;
      @(negedge clk);
      if (sif.o_ready) acc++;
      guard++;
    end
    chk("rst_mid accepted", acc, 3);
    @(posedge clk); #1;
    rstn = 1'b0; sif.i_row = 4'd3;
    @(negedge clk);
    chk("rst_mid weA_in_reset", we_A, 0);
    chk("rst_mid weB_in_reset", we_B, 0);
    @(posedge clk); #1;
    rstn = 1'b1; sif.i_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid weA", we_A, 0);
    chk("rst_mid weB", we_B, 0);
    chk("rst_mid ready", sif.o_ready, 0);
    chk("rst_mid nnz", nnz, 0);
    chk("rst_mid error", err, 0);
  endtask

  initial begin
    sif.i_valid = 1'b0; sif.i_row = '0; sif.i_col = '0; sif.i_val = '0; sif.i_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset weA", we_A, 0);
    chk("reset weB", we_B, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ready", sif.o_ready, 0);
    chk("reset nnz", nnz, 0);
    chk("reset error", err, 0);
    @(posedge clk); #1; rstn = 1'b1;

    set_diag();
    run_load("diag", 0, 1'b1);

    e_row = {0, 5}; e_col = {3, 2}; e_val = {1, 4};
    run_load("empty_rows", 0, 1'b1);

    set_diag();
    run_load("diag_gaps", 40, 1'b0);

    for (int t = 0; t < 8; t++) begin
      gen_random($urandom_range(1, 48));
      run_load($sformatf("rand%0d", t), (t % 2 == 0) ? 0 : 30, (t % 2 == 0));
    end

`ifdef SPMV_CSR_ORDER_CHECK_EN
    e_row = {3, 1, 4}; e_col = {0, 1, 0}; e_val = {1, 2, 3};
    run_load("order_err", 0, 1'b1);

    e_row.delete(); e_col.delete(); e_val.delete();
    for (int i = 0; i < MAX_NNZ + 1; i++) begin
      e_row.push_back(0); e_col.push_back(i % 16); e_val.push_back(1000 + i);
    end
    run_load("overflow", 0, 1'b1);
`endif

    reset_mid_stream();
    set_diag();
    run_load("after_reset", 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
